// File: rtl/sumador_serie_nibble_pkg.sv
// Shared constants and types for the nibble-serial adder.
// Holds the nibble width, FSM state encoding and counter sizing helper.
package sumador_serie_nibble_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sumador_serie_nibble_adder.sv
// 4-bit ripple-carry adder shared by every nibble of a serial operation.
// Purely combinational; the caller registers the carry between nibbles.
module sumador_4bit
    import sumador_serie_nibble_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              ci,
    output logic [NIBBLE-1:0] s,
    output logic              co
);

    logic [NIBBLE:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < NIBBLE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[NIBBLE];

endmodule

// File: rtl/sumador_serie_nibble.sv
// Nibble-serial W-bit adder: one nibble per clock through sumador_4bit.
// Valid/ready on both sides; result registers hold until the next op ends.
module sumador_serie_nibble
    import sumador_serie_nibble_pkg::*;
#(
    parameter  int N_NIBBLES = 4,
    localparam int W         = NIBBLE * N_NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Sum,
    output logic         Cout,
    output logic         Ovf
);

    localparam int CW = cnt_width(N_NIBBLES);
    localparam logic [CW-1:0] IDX_LAST = CW'(N_NIBBLES - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  sha_q, sha_d;
    logic [W-1:0]  shb_q, shb_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          amsb_q, amsb_d;
    logic          bmsb_q, bmsb_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;

    logic [NIBBLE-1:0] nib_s;
    logic              nib_co;
    logic [W-1:0]      acc_shift;

    sumador_4bit u_add (
        .a  (sha_q[NIBBLE-1:0]),
        .b  (shb_q[NIBBLE-1:0]),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    // New nibble enters from the MSB side so the last one lands on top.
    assign acc_shift = (acc_q >> NIBBLE) | (W'(nib_s) << (W - NIBBLE));

    always_comb begin
        state_d     = state_q;
        sha_d       = sha_q;
        shb_d       = shb_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        amsb_d      = amsb_q;
        bmsb_d      = bmsb_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sha_d      = A;
                    shb_d      = B;
                    carry_d    = Ci;
                    amsb_d     = A[W-1];
                    bmsb_d     = B[W-1];
                    acc_d      = '0;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                sha_d   = sha_q >> NIBBLE;
                shb_d   = shb_q >> NIBBLE;
                acc_d   = acc_shift;
                carry_d = nib_co;
                idx_d   = idx_q + CW'(1);
                if (idx_q == IDX_LAST) begin
                    idx_d       = '0;
                    sum_d       = acc_shift;
                    cout_d      = nib_co;
                    ovf_d       = amsb_q ^ bmsb_q ^ acc_shift[W-1] ^ nib_co;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sha_q       <= '0;
            shb_q       <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            amsb_q      <= 1'b0;
            bmsb_q      <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sha_q       <= sha_d;
            shb_q       <= shb_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            amsb_q      <= amsb_d;
            bmsb_q      <= bmsb_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_sumador_serie_nibble.sv
// Directed bench for sumador_serie_nibble with N_NIBBLES=4 (W=16).
// Expected values are hand-computed constants in each step.
module tb_sumador_serie_nibble;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Ci;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Sum;
    logic        Cout;
    logic        Ovf;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sumador_serie_nibble #(.N_NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Ci        (Ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic ci);
        @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        A        = a;
        B        = b;
        Ci       = ci;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("in_ready_in_calc", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat = i;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
    endtask

    task automatic check_res(input string tag, input logic [15:0] s,
                             input logic c, input logic v);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(Sum), 32'(s));
        chk({tag, "_cout"}, 32'(Cout), 32'(c));
        chk({tag, "_ovf"}, 32'(Ovf), 32'(v));
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a,
                          input logic [15:0] b, input logic ci,
                          input logic [15:0] s, input logic c,
                          input logic v);
        start_op(a, b, ci);
        wait_result(tag);
        check_res(tag, s, c, v);
        consume(tag);
    endtask

    initial begin
        logic seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        Ci        = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(Sum), 32'd0);
        chk("rst_cout", 32'(Cout), 32'd0);
        chk("rst_ovf", 32'(Ovf), 32'd0);

        run_op("carry_chain", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("ci_in", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        start_op(16'h8000, 16'h8000, 1'b0);
        wait_result("neg_ovf");
        check_res("neg_ovf", 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            A        = 16'h1111 * 16'(i + 1);
            B        = 16'h0F0F;
            Ci       = 1'b1;
            in_valid = 1'(i % 2 == 0);
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            check_res("bp_hold", 16'h0000, 1'b1, 1'b1);
        end
        in_valid = 1'b0;
        consume("bp");
        run_op("after_bp", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

        start_op(16'hAAAA, 16'h1111, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(Sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen_valid = seen_valid | out_valid;
        end
        chk("midrst_no_valid", 32'(seen_valid), 32'd0);
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
